// File: rtl/inst_loader_pkg.sv
// Shared types and defaults for the byte-stream program loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StHdr2,
    StData,
    StWrite,
    StCsum,
    StDone
  } state_e;

  localparam int unsigned HdrBytes        = 3;
  localparam int unsigned MaxWordsDefault = 2049;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and memory write-port bundle of the program loader.
interface inst_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              gravar_D;
  logic              write_os;
  logic [ADDR_W-1:0] write_address;
  logic [31:0]       data_write;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_written;

  // Loader side: consumes the byte stream, drives the memory write port.
  modport master (
    input  start, byte_in, byte_valid,
    output byte_ready, gravar_D, write_os, write_address, data_write,
           busy, done, error, words_written
  );

  // Host side: produces the byte stream, observes the write port.
  modport slave (
    output start, byte_in, byte_valid,
    input  byte_ready, gravar_D, write_os, write_address, data_write,
           busy, done, error, words_written
  );
endinterface

// File: rtl/inst_loader.sv
// Framed byte-stream loader writing big-endian words into the OS or program bank.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = MaxWordsDefault,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clock,
  input  logic          reset,
  inst_loader_if.master bus
);

  state_e      r_state, w_state_nxt, w_end_state;
  logic        w_ready, w_accept, w_last_word;
  logic [15:0] w_count_hdr;
  logic [15:0] r_count, r_idx;
  logic [1:0]  r_bcnt;
  logic [31:0] r_data;
  logic        r_os, r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_sum;
  assign w_end_state = StCsum;
`else
  assign w_end_state = StDone;
`endif

  assign w_count_hdr = {r_count[15:8], bus.byte_in};
  assign w_last_word = (r_idx + 16'd1) == r_count;
  assign w_accept    = w_ready & bus.byte_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_nxt = StHdr0;
      StHdr0:  if (w_accept) w_state_nxt = StHdr1;
      StHdr1:  if (w_accept) w_state_nxt = StHdr2;
      StHdr2: begin
        if (w_accept) begin
          if (w_count_hdr == 16'd0)                   w_state_nxt = w_end_state;
          else if (32'(w_count_hdr) > MAX_WORDS)      w_state_nxt = StDone;
          else                                        w_state_nxt = StData;
        end
      end
      StData:  if (w_accept && r_bcnt == 2'd3) w_state_nxt = StWrite;
      StWrite: w_state_nxt = w_last_word ? w_end_state : StData;
      StCsum:  if (w_accept) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      StHdr0, StHdr1, StHdr2, StData, StCsum: w_ready = 1'b1;
      default:                                w_ready = 1'b0;
    endcase
    bus.byte_ready    = w_ready;
    bus.gravar_D      = (r_state == StWrite);
    bus.busy          = (r_state != StIdle);
    bus.done          = (r_state == StDone);
    bus.write_os      = r_os;
    bus.write_address = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);
    bus.data_write    = r_data;
    bus.error         = r_err;
    bus.words_written = r_idx;
  end

  // Datapath: header capture, word assembly, index and sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_data  <= '0;
      r_os    <= 1'b0;
      r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      if (r_state == StIdle && bus.start) begin
        r_idx  <= '0;
        r_bcnt <= '0;
        r_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end
      if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
        r_sum <= r_sum + bus.byte_in;
`endif
        unique case (r_state)
          StHdr0: r_os <= bus.byte_in[0];
          StHdr1: r_count[15:8] <= bus.byte_in;
          StHdr2: begin
            r_count <= w_count_hdr;
            if (32'(w_count_hdr) > MAX_WORDS) r_err <= 1'b1;
          end
          StData: begin
            r_data <= {r_data[23:0], bus.byte_in};
            r_bcnt <= r_bcnt + 2'd1;
          end
`ifdef LOADER_CHECKSUM_EN
          StCsum: if (bus.byte_in != r_sum) r_err <= 1'b1;
`endif
          default: ;
        endcase
      end
      if (r_state == StWrite) r_idx <= r_idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader; checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned BASE = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  inst_loader_if #(.ADDR_W(AW)) bus ();

  inst_loader #(
    .ADDR_W   (AW),
    .MAX_WORDS(MaxWordsDefault),
    .BASE_ADDR(BASE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;
  int rdy_bad  = 0;
  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];
  logic [31:0] wq[$];

  // Observed writes: {write_os, write_address, data_write}
  always @(negedge clock) begin
    if (bus.gravar_D) begin
      got_q.push_back({bus.write_os, bus.write_address, bus.data_write});
      if (bus.byte_ready) rdy_bad++;
    end
    if (bus.done) done_cnt++;
  end

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    logic rdy;
    int   c;
    bit   fin;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    c   = 0;
    fin = 1'b0;
    while (!fin) begin
      rdy = bus.byte_ready;
      @(posedge clock);
      if (rdy || c >= 50) fin = 1'b1;
      @(negedge clock);
      c++;
    end
    bus.byte_valid = 1'b0;
    if (!rdy) begin
      n_checks++;
      n_errs++;
      $display("FAIL byte_accept: ready got 0 want 1 for byte %h", b);
    end
    if (gap) @(negedge clock);
  endtask

  task automatic wait_done(input int d0, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      #1;
      if (done_cnt != d0) seen = 1'b1;
      else @(negedge clock);
    end
    n_checks++;
    if (!seen) begin
      n_errs++;
      $display("FAIL %s_done_timeout: done pulses got 0 want 1", name);
    end
    @(negedge clock);
    #1;
  endtask

  // Sends a complete frame; expected writes are pushed as the data goes out.
  task automatic send_frame(input logic [7:0] h0, input logic [15:0] n, input bit gap,
                            input bit bad_sum, input bit with_start);
    logic [7:0] sum;
    logic [7:0] hb [3];
    logic [31:0] w;
    sum   = 8'h00;
    hb[0] = h0;
    hb[1] = n[15:8];
    hb[2] = n[7:0];
    if (with_start) do_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(hb[i], gap);
      sum = sum + hb[i];
    end
    if (32'(n) <= MaxWordsDefault) begin
      for (int i = 0; i < wq.size(); i++) begin
        w = wq[i];
        exp_q.push_back({h0[0], 32'(BASE + i), w});
        for (int k = 3; k >= 0; k--) begin
          send_byte(w[k*8 +: 8], gap);
          sum = sum + w[k*8 +: 8];
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(sum + {7'd0, bad_sum}, gap);
`endif
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.gravar_D, bus.done, bus.error, bus.byte_ready, bus.write_os} !== 6'b0) begin
      n_errs++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.busy, bus.gravar_D, bus.done, bus.error, bus.byte_ready, bus.write_os});
    end
    n_checks++;
    if (bus.words_written !== 16'd0) begin
      n_errs++; $display("FAIL reset_words: got %0d want 0", bus.words_written);
    end
    n_checks++;
    if (bus.write_address !== 32'd0) begin
      n_errs++; $display("FAIL reset_addr: got %h want 0", bus.write_address);
    end
    n_checks++;
    if (bus.data_write !== 32'd0) begin
      n_errs++; $display("FAIL reset_data: got %h want 0", bus.data_write);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_two_words();
    int d0;
    logic [64:0] e, g;
    d0 = done_cnt;
    wq = '{32'h11223344, 32'hAABBCCDD};
    send_frame(8'h01, 16'd2, 1'b0, 1'b0, 1'b1);
    wait_done(d0, "two_words");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : {65{1'bx}};
      n_checks++;
      if (g !== e) begin n_errs++; $display("FAIL two_words_write: got %h want %h", g, e); end
    end
    n_checks++;
    if (got_q.size() != 0) begin
      n_errs++; $display("FAIL two_words_extra: got %0d extra writes want 0", got_q.size());
      got_q.delete();
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_errs++; $display("FAIL two_words_done: got %0d pulses want 1", done_cnt - d0);
    end
    n_checks++;
    if ({bus.busy, bus.error, bus.write_os, bus.words_written} !== {1'b0, 1'b0, 1'b1, 16'd2}) begin
      n_errs++;
      $display("FAIL two_words_status: got busy=%b err=%b os=%b ww=%0d want 0 0 1 2",
               bus.busy, bus.error, bus.write_os, bus.words_written);
    end
  endtask

  task automatic test_empty();
    int d0;
    d0 = done_cnt;
    wq.delete();
    send_frame(8'h00, 16'd0, 1'b0, 1'b0, 1'b1);
    wait_done(d0, "empty");
    n_checks++;
    if (got_q.size() != 0) begin
      n_errs++; $display("FAIL empty_writes: got %0d want 0", got_q.size()); got_q.delete();
    end
    n_checks++;
    if ({bus.error, bus.write_os, bus.busy} !== 3'b000) begin
      n_errs++; $display("FAIL empty_status: got err/os/busy %b want 000",
                         {bus.error, bus.write_os, bus.busy});
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_errs++; $display("FAIL empty_done: got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reject();
    int d0;
    d0 = done_cnt;
    wq.delete();
    send_frame(8'h00, 16'h0802, 1'b0, 1'b0, 1'b1);
    wait_done(d0, "reject");
    n_checks++;
    if (bus.error !== 1'b1) begin n_errs++; $display("FAIL reject_error: got %b want 1", bus.error); end
    n_checks++;
    if (got_q.size() != 0) begin
      n_errs++; $display("FAIL reject_writes: got %0d want 0", got_q.size()); got_q.delete();
    end
    n_checks++;
    if (bus.words_written !== 16'd0) begin
      n_errs++; $display("FAIL reject_words: got %0d want 0", bus.words_written);
    end
    do_start();
    #1;
    n_checks++;
    if (bus.error !== 1'b0) begin n_errs++; $display("FAIL reject_clear: got %b want 0", bus.error); end
    d0 = done_cnt;
    send_frame(8'h00, 16'd0, 1'b0, 1'b0, 1'b0);
    wait_done(d0, "reject_next");
    n_checks++;
    if (bus.error !== 1'b0) begin n_errs++; $display("FAIL reject_next_err: got %b want 0", bus.error); end
  endtask

  task automatic test_gaps();
    int d0;
    logic [64:0] e, g;
    d0 = done_cnt;
    rdy_bad = 0;
    wq = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
    send_frame(8'hFE, 16'd3, 1'b1, 1'b0, 1'b1);
    wait_done(d0, "gaps");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : {65{1'bx}};
      n_checks++;
      if (g !== e) begin n_errs++; $display("FAIL gaps_write: got %h want %h", g, e); end
    end
    n_checks++;
    if (got_q.size() != 0) begin
      n_errs++; $display("FAIL gaps_extra: got %0d want 0", got_q.size()); got_q.delete();
    end
    n_checks++;
    if (rdy_bad != 0) begin n_errs++; $display("FAIL gaps_ready_in_write: got %0d want 0", rdy_bad); end
    n_checks++;
    if (bus.words_written !== 16'd3) begin
      n_errs++; $display("FAIL gaps_words: got %0d want 3", bus.words_written);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [64:0] e, g;
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.gravar_D, bus.done, bus.error, bus.write_os, bus.byte_ready} !== 6'b0) begin
      n_errs++; $display("FAIL reset_mid_flags: got %b want 000000",
                         {bus.busy, bus.gravar_D, bus.done, bus.error, bus.write_os, bus.byte_ready});
    end
    n_checks++;
    if ({bus.data_write, bus.words_written} !== 48'd0) begin
      n_errs++; $display("FAIL reset_mid_regs: got data=%h ww=%0d want 0 0",
                         bus.data_write, bus.words_written);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if (got_q.size() != 0) begin
      n_errs++; $display("FAIL reset_mid_writes: got %0d want 0", got_q.size()); got_q.delete();
    end
    d0 = done_cnt;
    wq = '{32'hCAFEF00D};
    send_frame(8'h00, 16'd1, 1'b0, 1'b0, 1'b1);
    wait_done(d0, "reset_mid_next");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : {65{1'bx}};
      n_checks++;
      if (g !== e) begin n_errs++; $display("FAIL reset_mid_next_write: got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [64:0] e, g;
    d0 = done_cnt;
    wq = '{32'h0000_0001, 32'hFFFF_FFFE};
    send_frame(8'h00, 16'd2, 1'b0, 1'b0, 1'b1);
    wait_done(d0, "b2b_first");
    wq = '{32'h7E57_0042};
    send_frame(8'h03, 16'd1, 1'b0, 1'b0, 1'b1);
    wait_done(d0 + 1, "b2b_second");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() != 0) ? got_q.pop_front() : {65{1'bx}};
      n_checks++;
      if (g !== e) begin n_errs++; $display("FAIL b2b_write: got %h want %h", g, e); end
    end
    n_checks++;
    if (got_q.size() != 0) begin
      n_errs++; $display("FAIL b2b_extra: got %0d want 0", got_q.size()); got_q.delete();
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int d0;
    logic [64:0] e, g;
    for (int bad = 0; bad < 2; bad++) begin
      d0 = done_cnt;
      wq = '{32'h01020304};
      send_frame(8'h00, 16'd1, 1'b0, bad[0], 1'b1);
      wait_done(d0, "csum");
      n_checks++;
      if (bus.error !== bad[0]) begin
        n_errs++; $display("FAIL csum_error: got %b want %b", bus.error, bad[0]);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = (got_q.size() != 0) ? got_q.pop_front() : {65{1'bx}};
        n_checks++;
        if (g !== e) begin n_errs++; $display("FAIL csum_write: got %h want %h", g, e); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_empty();
    test_reject();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
